// File: rtl/audio_rate_adapter_pkg.sv
// rtl/audio_rate_adapter_pkg.sv - shared audio coding types, frame record and pacing helpers
package audio_rate_adapter_pkg;

   typedef enum logic [1:0] {
      k37Khz = 2'd0,
      k18Khz = 2'd1,
      k44Khz = 2'd2
   } rate_e;

   typedef enum logic [1:0] {
      kBps4  = 2'd0,
      kBps8  = 2'd1,
      kBps16 = 2'd2
   } bps_e;

   typedef enum logic {
      kMono   = 1'b0,
      kStereo = 1'b1
   } chan_e;

   typedef struct packed {
      rate_e rate;
      bps_e  bps;
      chan_e chan;
   } header_coding_s;

   // One buffered output frame; rate travels with the frame so a rate
   // change lands exactly on the frame boundary at the output.
   typedef struct packed {
      logic [15:0] left;
      logic [15:0] right;
      rate_e       rate;
   } frame_s;

   function automatic logic is_stereo(input header_coding_s coding);
      return coding.chan == kStereo;
   endfunction

   // 18.9 kHz frames consume every second 37.8 kHz tick, tracked by phase.
   function automatic logic pop_due(input rate_e rate, input logic t44,
                                    input logic t37, input logic phase);
      logic due;
      case (rate)
         k44Khz:  due = t44;
         k37Khz:  due = t37;
         k18Khz:  due = t37 & phase;
         default: due = 1'b0;
      endcase
      return due;
   endfunction

endpackage

// File: rtl/audiostream.sv
// rtl/audiostream.sv - sample stream with source-held write and sink-driven accept strobe
interface audiostream;
   logic [15:0] sample;
   logic        write;
   logic        strobe;

   modport sink   (input sample, input write, output strobe);
   modport source (output sample, output write, input strobe);
endinterface

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - frame FIFO with synchronous write, registered read and head-rate peek
module audio_frame_fifo
   import audio_rate_adapter_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  frame_s                   i_wdata,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output frame_s                   o_rdata,
   output rate_e                    o_head_rate,
   output logic [$clog2(DEPTH):0]   o_fill,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   frame_s         r_mem      [DEPTH];
   rate_e          r_rate_mem [DEPTH];
   frame_s         r_rdata;
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_count;

   // Frame storage; the narrow rate copy gives the pacer an unregistered view of the head.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wptr]      <= i_wdata;
         r_rate_mem[r_wptr] <= i_wdata.rate;
      end
   end

   // Registered read port, updated only on a pop so the last frame is held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (i_pop) begin
         r_rdata <= r_mem[r_rptr];
      end
   end

   // Pointers wrap naturally at DEPTH; the count disambiguates full from empty.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata     = r_rdata;
   assign o_head_rate = r_rate_mem[r_rptr];
   assign o_fill      = r_count;
   assign o_empty     = (r_count == '0);
   assign o_full      = (r_count == FULL_COUNT);

endmodule

// File: rtl/audio_rate_adapter.sv
// rtl/audio_rate_adapter.sv - pairs incoming samples into frames and releases them at the frame's audio rate
module audio_rate_adapter
   import audio_rate_adapter_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   audiostream.sink                      in,
   input  logic                          in_channel,
   input  header_coding_s                in_coding,
   input  logic                          tick_44k,
   input  logic                          tick_37k8,
   input  logic                          flush,
   output logic [15:0]                   left,
   output logic [15:0]                   right,
   output logic                          frame_valid,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);

   logic        w_empty;
   logic        w_full;
   rate_e       w_head_rate;
   rate_e       w_rate;
   logic        w_due;
   logic        w_pop;
   logic        w_can_push;
   logic        w_strobe;
   logic        w_stereo;
   logic        w_push;
   frame_s      w_push_frame;
   frame_s      w_rd_frame;
   logic        w_unused;

   logic        r_phase;
   logic        r_strobe_q;
   logic        r_armed;
   logic [15:0] r_left_hold;
   logic        r_pair_pending;
   logic        r_frame_valid;
   logic        r_underflow;

   // An empty FIFO has no head frame, so it falls back to 37.8 kHz pacing.
   assign w_rate = w_empty ? k37Khz : w_head_rate;
   assign w_due  = pop_due(w_rate, tick_44k, tick_37k8, r_phase);
   assign w_pop  = w_due && !w_empty && !flush;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_can_push = !w_full || w_pop;
   assign w_strobe   = in.write && r_armed && !r_strobe_q && w_can_push && !flush && !reset;
   assign in.strobe  = w_strobe;

   assign w_stereo = is_stereo(in_coding);
   assign w_push   = w_strobe && (!w_stereo || in_channel);

   // Mono duplicates the sample; a stereo right pairs with whatever left is held.
   always_comb begin
      w_push_frame       = '0;
      w_push_frame.left  = w_stereo ? r_left_hold : in.sample;
      w_push_frame.right = in.sample;
      w_push_frame.rate  = in_coding.rate;
   end

   audio_frame_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_wdata     (w_push_frame),
      .i_pop       (w_pop),
      .i_flush     (flush),
      .o_rdata     (w_rd_frame),
      .o_head_rate (w_head_rate),
      .o_fill      (fill),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );

   // Accept handshake state: strobe spacing and re-arm only after write has been seen low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_strobe_q <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_strobe_q <= w_strobe;
         if (!in.write) r_armed <= 1'b1;
      end
   end

   // Stereo left capture; a second left before its right simply overwrites.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_left_hold    <= '0;
         r_pair_pending <= 1'b0;
      end else if (flush) begin
         r_pair_pending <= 1'b0;
      end else if (w_strobe && w_stereo) begin
         if (!in_channel) begin
            r_left_hold    <= in.sample;
            r_pair_pending <= 1'b1;
         end else begin
            r_pair_pending <= 1'b0;
         end
      end
   end

   // 18.9 kHz phase: armed by a tick that did not pop, cleared by any pop or flush.
   always_ff @(posedge clk) begin
      if (reset || flush || w_pop) begin
         r_phase <= 1'b0;
      end else if (tick_37k8 && !w_empty && w_head_rate == k18Khz) begin
         r_phase <= 1'b1;
      end
   end

   // Output pulses line up with the FIFO read register loading the popped frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_valid <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_frame_valid <= w_pop;
         r_underflow   <= w_due && w_empty && !flush;
      end
   end

   assign left        = w_rd_frame.left;
   assign right       = w_rd_frame.right;
   assign frame_valid = r_frame_valid;
   assign underflow   = r_underflow;

   // bps, the stored frame rate and pair_pending carry no datapath role here.
   assign w_unused = ^{in_coding.bps, w_rd_frame.rate, r_pair_pending};

endmodule

// File: tb/tb_audio_rate_adapter.sv
// tb/tb_audio_rate_adapter.sv - directed table-driven bench for audio_rate_adapter
module tb_audio_rate_adapter;
   import audio_rate_adapter_pkg::*;

   typedef enum int {OP_WR, OP_T44, OP_T37} op_e;

   typedef struct {
      op_e         op;
      logic [15:0] data;
      logic        ch;
      rate_e       rate;
      logic        st;
      logic        fv;
      logic        uf;
      logic [15:0] l;
      logic [15:0] r;
      int          fill;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_channel;
   header_coding_s in_coding;
   logic           tick_44k;
   logic           tick_37k8;
   logic           flush;
   logic [15:0]    left;
   logic [15:0]    right;
   logic           frame_valid;
   logic           underflow;
   logic [4:0]     fill;

   audiostream aif ();

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];
   logic ok;

   audio_rate_adapter #(.FIFO_DEPTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .in          (aif),
      .in_channel  (in_channel),
      .in_coding   (in_coding),
      .tick_44k    (tick_44k),
      .tick_37k8   (tick_37k8),
      .flush       (flush),
      .left        (left),
      .right       (right),
      .frame_valid (frame_valid),
      .underflow   (underflow),
      .fill        (fill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input op_e op, input logic [15:0] d, input logic ch,
                               input rate_e r, input logic st, input logic fv, input logic uf,
                               input logic [15:0] l, input logic [15:0] rr, input int f);
      vec_t v;
      v.op = op; v.data = d; v.ch = ch; v.rate = r; v.st = st;
      v.fv = fv; v.uf = uf; v.l = l; v.r = rr; v.fill = f;
      vecs.push_back(v);
   endfunction

   // Starts at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic do_write(input logic [15:0] d, input logic ch, input rate_e r,
                           input logic st, output logic accepted);
      aif.sample     = d;
      in_channel     = ch;
      in_coding.rate = r;
      in_coding.chan = st ? kStereo : kMono;
      aif.write      = 1'b1;
      accepted       = 1'b0;
      for (int i = 0; i < 40 && !accepted; i++) begin
         @(negedge clk);
         if (aif.strobe) accepted = 1'b1;
         @(posedge clk); #1;
      end
      aif.write = 1'b0;
   endtask

   task automatic do_tick(input logic is44);
      if (is44) tick_44k = 1'b1; else tick_37k8 = 1'b1;
      @(posedge clk); #1;
      tick_44k  = 1'b0;
      tick_37k8 = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_channel = 1'b0; tick_44k = 1'b0; tick_37k8 = 1'b0; flush = 1'b0;
      in_coding = '{rate: k37Khz, bps: kBps16, chan: kMono};
      aif.sample = '0; aif.write = 1'b0;

      // op, data, ch, rate, stereo | fv, uf, left, right, fill
      add(OP_WR,  16'h0100, 0, k37Khz, 0, 0, 0, 16'h0000, 16'h0000, 1);
      add(OP_WR,  16'h0200, 0, k37Khz, 0, 0, 0, 16'h0000, 16'h0000, 2);
      add(OP_WR,  16'h0300, 0, k37Khz, 0, 0, 0, 16'h0000, 16'h0000, 3);
      add(OP_WR,  16'h0400, 0, k37Khz, 0, 0, 0, 16'h0000, 16'h0000, 4);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0100, 16'h0100, 3);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0200, 16'h0200, 2);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0300, 16'h0300, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0400, 16'h0400, 0);
      add(OP_WR,  16'h1111, 0, k44Khz, 1, 0, 0, 16'h0400, 16'h0400, 0);
      add(OP_WR,  16'h2222, 1, k44Khz, 1, 0, 0, 16'h0400, 16'h0400, 1);
      add(OP_WR,  16'h3333, 0, k44Khz, 1, 0, 0, 16'h0400, 16'h0400, 1);
      add(OP_WR,  16'h4444, 1, k44Khz, 1, 0, 0, 16'h0400, 16'h0400, 2);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h0400, 16'h0400, 2);
      add(OP_T44, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h1111, 16'h2222, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h1111, 16'h2222, 1);
      add(OP_T44, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h3333, 16'h4444, 0);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 1, 16'h3333, 16'h4444, 0);
      add(OP_T44, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h3333, 16'h4444, 0);
      add(OP_WR,  16'h0500, 0, k18Khz, 0, 0, 0, 16'h3333, 16'h4444, 1);
      add(OP_WR,  16'h0600, 0, k18Khz, 0, 0, 0, 16'h3333, 16'h4444, 2);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h3333, 16'h4444, 2);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0500, 16'h0500, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h0500, 16'h0500, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0600, 16'h0600, 0);
      add(OP_WR,  16'h0700, 0, k44Khz, 0, 0, 0, 16'h0600, 16'h0600, 1);
      add(OP_WR,  16'h0800, 0, k37Khz, 0, 0, 0, 16'h0600, 16'h0600, 2);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h0600, 16'h0600, 2);
      add(OP_T44, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0700, 16'h0700, 1);
      add(OP_T44, 16'h0000, 0, k37Khz, 0, 0, 0, 16'h0700, 16'h0700, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h0800, 16'h0800, 0);
      add(OP_WR,  16'h9999, 1, k37Khz, 1, 0, 0, 16'h0800, 16'h0800, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'h3333, 16'h9999, 0);
      add(OP_WR,  16'hAAAA, 0, k37Khz, 1, 0, 0, 16'h3333, 16'h9999, 0);
      add(OP_WR,  16'hBBBB, 0, k37Khz, 1, 0, 0, 16'h3333, 16'h9999, 0);
      add(OP_WR,  16'hCCCC, 1, k37Khz, 1, 0, 0, 16'h3333, 16'h9999, 1);
      add(OP_T37, 16'h0000, 0, k37Khz, 0, 1, 0, 16'hBBBB, 16'hCCCC, 0);

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_left", left, 16'h0000);
      chk("rst_right", right, 16'h0000);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_uf", underflow, 1'b0);
      chk("rst_fill", fill, 5'd0);
      chk("rst_strobe", aif.strobe, 1'b0);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_WR: begin
               do_write(vecs[i].data, vecs[i].ch, vecs[i].rate, vecs[i].st, ok);
               chk($sformatf("v%0d_accept", i), ok, 1'b1);
            end
            OP_T44:  do_tick(1'b1);
            default: do_tick(1'b0);
         endcase
         chk($sformatf("v%0d_fv", i), frame_valid, vecs[i].fv);
         chk($sformatf("v%0d_uf", i), underflow, vecs[i].uf);
         chk($sformatf("v%0d_left", i), left, vecs[i].l);
         chk($sformatf("v%0d_right", i), right, vecs[i].r);
         chk($sformatf("v%0d_fill", i), fill, 32'(vecs[i].fill));
         if (vecs[i].op != OP_WR) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse_end", i), {frame_valid, underflow}, 2'b00);
         end
      end

      // Full FIFO: 16 accepted, 17th waits until a pop frees a slot in the same cycle.
      for (int i = 0; i < 16; i++) begin
         do_write(16'h1000 + 16'(i), 1'b0, k37Khz, 1'b0, ok);
         chk($sformatf("full_wr%0d", i), ok, 1'b1);
      end
      chk("full_fill16", fill, 5'd16);
      aif.sample = 16'h1010; in_channel = 1'b0;
      in_coding.rate = k37Khz; in_coding.chan = kMono;
      aif.write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("full_hold_strobe%0d", i), aif.strobe, 1'b0);
         @(posedge clk); #1;
      end
      chk("full_hold_fill", fill, 5'd16);
      tick_37k8 = 1'b1;
      @(negedge clk);
      chk("full_pop_strobe", aif.strobe, 1'b1);
      @(posedge clk); #1;
      tick_37k8 = 1'b0; aif.write = 1'b0;
      chk("full_pop_fv", frame_valid, 1'b1);
      chk("full_pop_left", left, 16'h1000);
      chk("full_pop_fill", fill, 5'd16);
      for (int i = 0; i < 16; i++) begin
         do_tick(1'b0);
         chk($sformatf("drain%0d_fv", i), frame_valid, 1'b1);
         chk($sformatf("drain%0d_left", i), left, 16'h1001 + 16'(i));
      end
      chk("drain_fill", fill, 5'd0);

      // Flush with buffered frames and a pending left; the held left survives.
      for (int i = 0; i < 5; i++) begin
         do_write(16'h2000 + 16'(i), 1'b0, k37Khz, 1'b0, ok);
         chk($sformatf("fl_wr%0d", i), ok, 1'b1);
      end
      do_write(16'hDDDD, 1'b0, k37Khz, 1'b1, ok);
      chk("fl_left_wr", ok, 1'b1);
      chk("fl_fill5", fill, 5'd5);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_fill0", fill, 5'd0);
      chk("fl_left_kept", left, 16'h1010);
      chk("fl_right_kept", right, 16'h1010);
      do_write(16'hEEEE, 1'b1, k37Khz, 1'b1, ok);
      chk("fl_right_wr", ok, 1'b1);
      chk("fl_pair_fill", fill, 5'd1);
      do_tick(1'b0);
      chk("fl_pair_left", left, 16'hDDDD);
      chk("fl_pair_right", right, 16'hEEEE);

      // Flush clears the 18.9 kHz phase.
      do_write(16'h3000, 1'b0, k18Khz, 1'b0, ok);
      do_write(16'h3001, 1'b0, k18Khz, 1'b0, ok);
      do_tick(1'b0);
      chk("ph_tick1_fv", frame_valid, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      do_write(16'h3002, 1'b0, k18Khz, 1'b0, ok);
      chk("ph_fill1", fill, 5'd1);
      do_tick(1'b0);
      chk("ph_after_flush_fv", frame_valid, 1'b0);
      do_tick(1'b0);
      chk("ph_second_fv", frame_valid, 1'b1);
      chk("ph_second_left", left, 16'h3002);

      // Reset mid-transfer: a write held across reset is dropped until refreshed.
      aif.sample = 16'h4444; in_coding.rate = k37Khz; in_coding.chan = kMono;
      aif.write = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_left", left, 16'h0000);
      chk("mid_rst_fill", fill, 5'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_stale_strobe%0d", i), aif.strobe, 1'b0);
         @(posedge clk); #1;
      end
      aif.write = 1'b0;
      @(posedge clk); #1;
      aif.sample = 16'h5555; aif.write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("spacing_strobe%0d", i), aif.strobe, (i % 2 == 0) ? 1'b1 : 1'b0);
         @(posedge clk); #1;
      end
      aif.write = 1'b0;
      chk("spacing_fill", fill, 5'd2);
      do_tick(1'b0);
      chk("fresh_left", left, 16'h5555);
      chk("fresh_fv", frame_valid, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_rate_adapter.md
AUDIO_RATE_ADAPTER -- requirements
Module: audio_rate_adapter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning frame FIFO depth; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in, an audiostream.sink: sample[15:0], write (source valid), strobe (driven here, accept).
REQ-005 SHALL have port in_channel, input, 1 bit: 0 left, 1 right; meaningful only for stereo coding.
REQ-006 SHALL have port in_coding, input, header_coding_s: rate, bps and chan of the offered sample.
REQ-007 SHALL have port tick_44k, input, 1 bit: single-cycle 44.1 kHz pacing strobe.
REQ-008 SHALL have port tick_37k8, input, 1 bit: single-cycle 37.8 kHz pacing strobe.
REQ-009 SHALL have port flush, input, 1 bit: discard all buffered audio.
REQ-010 SHALL have port left, output, 16 bits: current left output sample.
REQ-011 SHALL have port right, output, 16 bits: current right output sample.
REQ-012 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when left and right update.
REQ-013 SHALL have port underflow, output, 1 bit: one-cycle pulse on a due pop with an empty FIFO.
REQ-014 SHALL have port fill, output, log2(FIFO_DEPTH)+1 bits: number of frames buffered.

Function
REQ-015 SHALL assert in.strobe for exactly one cycle to accept a sample, only while in.write is 1, and never on two consecutive cycles.
REQ-016 SHALL accept a sample only when the FIFO is not full; while full, SHALL hold in.strobe at 0 and leave in.write pending.
REQ-017 SHALL, for mono coding (chan != kStereo), push frame {sample, sample} with in_coding.rate.
REQ-018 SHALL, for stereo coding with in_channel 0, store the sample in left_hold and set pair_pending without pushing anything.
REQ-019 SHALL, for stereo coding with in_channel 1, push {left_hold, sample} with in_coding.rate and clear pair_pending; it pushes even when pair_pending is 0.
REQ-020 SHALL, when a second left sample arrives while pair_pending is 1, overwrite left_hold.
REQ-021 SHALL store each FIFO entry as 34 bits: left[15:0], right[15:0] and rate[1:0].
REQ-022 SHALL treat rate as a property of the frame at the FIFO head, so that a rate change in the input stream takes effect at the frame boundary on the output.
REQ-023 SHALL make a pop due as follows: on tick_44k for head rate k44Khz; on tick_37k8 for k37Khz; on every second tick_37k8 for k18Khz.
REQ-024 SHALL clear the 18.9 kHz phase bit on every pop and on flush, so that the first k18Khz pop after either occurs on the second tick_37k8.
REQ-025 SHALL, on a due pop with a non-empty FIFO, load left and right on the next cycle and pulse frame_valid for one cycle; latency is tick to output equals 1 cycle.
REQ-026 SHALL, on an empty FIFO, use tick_37k8 pacing; a due pop SHALL hold left and right unchanged and pulse underflow.
REQ-027 SHALL, when push and pop occur in the same cycle, perform both; fill is unchanged, and the FIFO SHALL be full-safe because a pop frees a slot in that cycle.
REQ-028 SHALL let read and write pointers wrap modulo FIFO_DEPTH; full is fill == FIFO_DEPTH and empty is fill == 0.
REQ-029 SHALL, on flush, empty the FIFO, clear pair_pending and suppress any push in that cycle; left and right SHALL keep their values.
REQ-030 SHALL treat bps as informational only; samples SHALL arrive already 16-bit.

Reset
REQ-031 SHALL, on reset, set left = 0, right = 0, frame_valid = 0, underflow = 0, in.strobe = 0, fill = 0, both pointers = 0, pair_pending = 0, left_hold = 0 and phase = 0.
REQ-032 SHALL, on reset mid-transfer, drop any pending sample; a subsequent strobe SHALL be issued only against a fresh write.

Structure
REQ-033 SHALL use header_coding_s and the rate, bps and chan enums from the shared audio types package; the frame struct {left, right, rate} SHALL be added to that package.
REQ-034 SHALL isolate the FIFO storage and pointers in one sub-module, audio_frame_fifo (synchronous write, registered read), suited to block RAM inference.

Verification
REQ-035 Mono k37Khz: 4 samples 0x0100..0x0400, then 4 tick_37k8 -> 4 frame_valid pulses, each one cycle after its tick, with left = right = 0x0100..0x0400 in order.
REQ-036 Stereo k44Khz: L=0x1111, R=0x2222, L=0x3333, R=0x4444, then 2 tick_44k -> frames (0x1111,0x2222) and (0x3333,0x4444); tick_37k8 pulses are ignored.
REQ-037 k18Khz: 2 mono frames, then 4 tick_37k8 -> frame_valid only after ticks 2 and 4.
REQ-038 Full: 17 mono writes with no ticks -> 16 strobes, fill = 16, 17th write stays pending; one tick -> 17th sample is accepted and fill stays 16.
REQ-039 Underflow: empty FIFO, tick_37k8 -> underflow pulses and left and right are unchanged; flush with fill = 5 and a pending left -> fill = 0 and the next right sample pairs with left_hold.
